// File: rtl/ucode_seq_pkg.sv
// Shared microcode types, flow classification and ROM template table for the
// ucode sequencer. Also carries the uinstr and nuke packet shapes used at its ports.
package ucode_seq_pkg;

  localparam int MAX_FLOW_DEF  = 4;
  localparam int ROM_DEPTH_DEF = 32;
  localparam int ROM_AW        = $clog2(ROM_DEPTH_DEF);

  typedef logic [7:0] t_uop;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  simid;
    t_uop        uop;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [15:0] imm;
  } t_uinstr;

  typedef struct packed {
    logic       valid;
    logic [7:0] simid;
  } t_nuke_pkt;

  typedef t_uinstr t_uc_rom_entry;

  // Opcodes with bit 7 set are microcoded; low two bits give (length - 1).
  function automatic logic [7:0] f_uc_flow_len(t_uop uop);
    return uop[7] ? (8'(uop[1:0]) + 8'd1) : 8'd1;
  endfunction

  // Each microcoded opcode owns a 4-entry slot in the ROM.
  function automatic logic [ROM_AW-1:0] f_uc_base(t_uop uop);
    return {uop[4:2], 2'b00};
  endfunction

  function automatic t_uc_rom_entry f_uc_rom(logic [ROM_AW-1:0] idx);
    t_uc_rom_entry e;
    e      = '0;
    e.uop  = 8'h40 | 8'(idx);
    e.dst  = 5'(idx);
    e.imm  = 16'hA000 | 16'(idx);
    return e;
  endfunction

  function automatic string describe_flow(t_uop uop);
    return $sformatf("uop %02h: len %0d base %0d", uop, f_uc_flow_len(uop), f_uc_base(uop));
  endfunction

endpackage

// File: rtl/ucode_seq_rom.sv
// Combinational microcode template lookup; kept separate so it can become
// an SRAM macro without touching the sequencer.
module uc_rom
  import ucode_seq_pkg::*;
#(
  parameter int ROM_DEPTH = ROM_DEPTH_DEF,
  localparam int ADDRW    = $clog2(ROM_DEPTH)
) (
  input  logic [ADDRW-1:0] idx,
  output t_uc_rom_entry    entry
);

  assign entry = f_uc_rom(ROM_AW'(idx));

endmodule

// File: rtl/ucode_seq.sv
// Microcode sequencer between decode and rename: passes single-uop parents
// straight through and expands microcoded parents into ROM flows, one uop/cycle.
module ucode_seq
  import ucode_seq_pkg::*;
#(
  parameter int MAX_FLOW  = MAX_FLOW_DEF,
  parameter int ROM_DEPTH = ROM_DEPTH_DEF,
  localparam int IDXW     = (MAX_FLOW > 1) ? $clog2(MAX_FLOW) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  t_nuke_pkt       nuke_rb1,
  input  logic            valid_de1,
  input  t_uinstr         uinstr_de1,
  output logic            ucode_ready_uc0,
  input  logic            rename_ready_rn0,
  output logic            valid_uc1,
  output t_uinstr         uinstr_uc1,
  output logic            sop_uc1,
  output logic            eom_uc1,
  output logic [IDXW-1:0] flow_idx_uc1
);

  localparam int LENW  = $clog2(MAX_FLOW + 1);
  localparam int ADDRW = $clog2(ROM_DEPTH);
  localparam int SUMW  = ADDRW + 1;

  typedef enum logic {IDLE, FLOW} t_state;

  typedef struct packed {
    logic            valid;
    t_uop            uop;
    logic [31:0]     pc;
    logic [7:0]      simid;
    logic [LENW-1:0] len;
    logic [IDXW-1:0] next_idx;
  } t_pend;

  t_state state_q, state_d;
  t_pend  pend_q, pend_d;

  logic            out_vld_q;
  t_uinstr         out_uinstr_q;
  logic            out_sop_q, out_eom_q;
  logic [IDXW-1:0] out_idx_q;

  logic            nuke, out_free, accept, flow_go, parent_multi;
  logic [7:0]      parent_len8;
  logic [LENW-1:0] parent_len;
  logic [ROM_AW-1:0] rom_base;
  logic [IDXW-1:0] rom_off;
  logic [SUMW-1:0] rom_sum;
  t_uc_rom_entry   rom_entry;
  t_uinstr         merged;
  logic            ld, ld_sop, ld_eom;
  t_uinstr         ld_uinstr;
  logic [IDXW-1:0] ld_idx;
  logic            unused_nuke;

  assign unused_nuke = ^nuke_rb1.simid;

  assign nuke         = nuke_rb1.valid;
  assign out_free     = ~out_vld_q | rename_ready_rn0;
  assign ucode_ready_uc0 = (state_q == IDLE) & out_free & ~nuke & ~reset;
  assign accept       = valid_de1 & ucode_ready_uc0;
  assign flow_go      = (state_q == FLOW) & pend_q.valid & out_free & ~nuke;

  assign parent_len8  = f_uc_flow_len(uinstr_de1.uop);
  assign parent_len   = LENW'(parent_len8);
  assign parent_multi = parent_len != LENW'(1);

  // A new parent always starts at offset 0; otherwise continue the held flow.
  assign rom_base = accept ? f_uc_base(uinstr_de1.uop) : f_uc_base(pend_q.uop);
  assign rom_off  = accept ? '0 : pend_q.next_idx;
  assign rom_sum  = SUMW'(rom_base) + SUMW'(rom_off);

  uc_rom #(.ROM_DEPTH(ROM_DEPTH)) u_rom (
    .idx   (rom_sum[ADDRW-1:0]),
    .entry (rom_entry)
  );

  always_comb begin
    merged       = rom_entry;
    merged.pc    = accept ? uinstr_de1.pc    : pend_q.pc;
    merged.simid = accept ? uinstr_de1.simid : pend_q.simid;
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ld        = 1'b0;
    ld_uinstr = out_uinstr_q;
    ld_sop    = 1'b0;
    ld_eom    = 1'b0;
    ld_idx    = '0;
    if (accept) begin
      ld     = 1'b1;
      ld_sop = 1'b1;
      if (!parent_multi) begin
        ld_uinstr = uinstr_de1;
        ld_eom    = 1'b1;
      end else begin
        ld_uinstr       = merged;
        pend_d.valid    = 1'b1;
        pend_d.uop      = uinstr_de1.uop;
        pend_d.pc       = uinstr_de1.pc;
        pend_d.simid    = uinstr_de1.simid;
        pend_d.len      = parent_len;
        pend_d.next_idx = IDXW'(1);
        state_d         = FLOW;
      end
    end else if (flow_go) begin
      ld              = 1'b1;
      ld_uinstr       = merged;
      ld_idx          = pend_q.next_idx;
      ld_eom          = (LENW'(pend_q.next_idx) + LENW'(1)) == pend_q.len;
      pend_d.next_idx = pend_q.next_idx + IDXW'(1);
      if (ld_eom) begin
        pend_d.valid = 1'b0;
        state_d      = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      out_vld_q    <= 1'b0;
      out_uinstr_q <= '0;
      out_sop_q    <= 1'b0;
      out_eom_q    <= 1'b0;
      out_idx_q    <= '0;
    end else if (nuke) begin
      // An emit in the nuke cycle has already been taken by rename.
      state_q   <= IDLE;
      pend_q    <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (ld) begin
        out_vld_q    <= 1'b1;
        out_uinstr_q <= ld_uinstr;
        out_sop_q    <= ld_sop;
        out_eom_q    <= ld_eom;
        out_idx_q    <= ld_idx;
      end else if (out_free) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign valid_uc1    = out_vld_q;
  assign uinstr_uc1   = out_uinstr_q;
  assign sop_uc1      = out_sop_q;
  assign eom_uc1      = out_eom_q;
  assign flow_idx_uc1 = out_idx_q;

  a_no_push_when_busy: assert property (@(posedge clk) disable iff (reset)
    valid_de1 |-> ucode_ready_uc0);

  a_flow_len_range: assert property (@(posedge clk) disable iff (reset)
    accept |-> (parent_len8 != 8'd0) && (parent_len8 <= 8'(MAX_FLOW)));

  a_rom_idx_range: assert property (@(posedge clk) disable iff (reset)
    ((accept & parent_multi) | flow_go) |-> (rom_sum < SUMW'(ROM_DEPTH)));

  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    (valid_uc1 & ~rename_ready_rn0 & ~nuke) |=>
      (valid_uc1 && $stable(uinstr_uc1) && $stable(sop_uc1) &&
       $stable(eom_uc1) && $stable(flow_idx_uc1)));

  a_mid_flow_no_sop: assert property (@(posedge clk) disable iff (reset)
    (valid_uc1 & rename_ready_rn0 & ~eom_uc1 & ~nuke) |=> (valid_uc1 & ~sop_uc1));

  a_sop_after_eom: assert property (@(posedge clk) disable iff (reset)
    (valid_uc1 & rename_ready_rn0 & eom_uc1) |=> (~valid_uc1 | sop_uc1));

  a_sop_idx0: assert property (@(posedge clk) disable iff (reset)
    (valid_uc1 & sop_uc1) |-> (flow_idx_uc1 == '0));

endmodule

// File: tb/tb_ucode_seq.sv
// Directed bench for ucode_seq: stimulus pushes hand-computed uops into a
// scoreboard queue, a negedge monitor pops and compares on every emit.
module tb_ucode_seq;
  import ucode_seq_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  t_nuke_pkt nuke_rb1;
  logic      valid_de1;
  t_uinstr   uinstr_de1;
  logic      ucode_ready_uc0;
  logic      rename_ready_rn0;
  logic      valid_uc1;
  t_uinstr   uinstr_uc1;
  logic      sop_uc1, eom_uc1;
  logic [1:0] flow_idx_uc1;

  typedef struct packed {
    t_uinstr    u;
    logic       sop;
    logic       eom;
    logic [1:0] idx;
  } t_exp;

  t_exp exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ucode_seq dut (
    .clk              (clk),
    .reset            (reset),
    .nuke_rb1         (nuke_rb1),
    .valid_de1        (valid_de1),
    .uinstr_de1       (uinstr_de1),
    .ucode_ready_uc0  (ucode_ready_uc0),
    .rename_ready_rn0 (rename_ready_rn0),
    .valid_uc1        (valid_uc1),
    .uinstr_uc1       (uinstr_uc1),
    .sop_uc1          (sop_uc1),
    .eom_uc1          (eom_uc1),
    .flow_idx_uc1     (flow_idx_uc1)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic chku(input string name, input t_uinstr act, input t_uinstr expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  function automatic t_uinstr mk(input logic [31:0] pc, input logic [7:0] simid,
                                 input logic [7:0] uop, input logic [4:0] dst,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [15:0] imm);
    t_uinstr u;
    u.pc = pc; u.simid = simid; u.uop = uop; u.dst = dst;
    u.src1 = s1; u.src2 = s2; u.imm = imm;
    return u;
  endfunction

  task automatic push(input t_uinstr u, input logic sop, input logic eom, input logic [1:0] idx);
    t_exp e;
    e.u = u; e.sop = sop; e.eom = eom; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Only drives valid_de1 when the sequencer is ready, never against backpressure.
  task automatic issue(input string name, input t_uinstr u);
    #1;
    chk(name, 32'(ucode_ready_uc0), 1);
    if (ucode_ready_uc0) begin
      valid_de1  = 1'b1;
      uinstr_de1 = u;
    end
  endtask

  always @(negedge clk) begin
    t_exp e;
    if (valid_uc1 === 1'b1 && rename_ready_rn0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got uop %0h idx %0d, required no output", uinstr_uc1.uop, flow_idx_uc1);
      end else begin
        e = exp_q.pop_front();
        chku("sb_uinstr", uinstr_uc1, e.u);
        chk("sb_sop", 32'(sop_uc1), 32'(e.sop));
        chk("sb_eom", 32'(eom_uc1), 32'(e.eom));
        chk("sb_idx", 32'(flow_idx_uc1), 32'(e.idx));
      end
    end
  end

  initial begin
    t_uinstr p;
    reset = 1'b1; nuke_rb1 = '0; valid_de1 = 1'b0; uinstr_de1 = '0; rename_ready_rn0 = 1'b0;
    $display("[TB] %s", describe_flow(8'h86));

    // Reset state
    step;
    chk("rst_ready_low", 32'(ucode_ready_uc0), 0);
    step;
    chk("rst_valid", 32'(valid_uc1), 0);
    chku("rst_uinstr", uinstr_uc1, '0);
    chk("rst_sop_eom_idx", 32'({sop_uc1, eom_uc1, flow_idx_uc1}), 0);
    reset = 1'b0; rename_ready_rn0 = 1'b1;
    #1 chk("post_rst_ready", 32'(ucode_ready_uc0), 1);

    // Pass-through: 8 back-to-back single-uop parents
    for (int i = 0; i < 8; i++) begin
      p = mk(32'h200 + 32'(4 * i), 8'(i), 8'h10 + 8'(i), 5'(i), 5'd3, 5'd9, 16'h1000 + 16'(i));
      issue("pt_ready", p);
      push(p, 1'b1, 1'b1, 2'd0);
      step;
      chk("pt_valid", 32'(valid_uc1), 1);
      chk("pt_sop_eom_idx", 32'({sop_uc1, eom_uc1, flow_idx_uc1}), 32'h0C);
    end
    valid_de1 = 1'b0;
    step;
    chk("pt_drain", 32'(valid_uc1), 0);

    // Flow expand: len-3 parent 0x86 -> ROM 4..6
    p = mk(32'h100, 8'h05, 8'h86, 5'd7, 5'd3, 5'd9, 16'h1234);
    issue("fx_ready", p);
    push(mk(32'h100, 8'h05, 8'h44, 5'd4, 5'd0, 5'd0, 16'hA004), 1'b1, 1'b0, 2'd0);
    push(mk(32'h100, 8'h05, 8'h45, 5'd5, 5'd0, 5'd0, 16'hA005), 1'b0, 1'b0, 2'd1);
    push(mk(32'h100, 8'h05, 8'h46, 5'd6, 5'd0, 5'd0, 16'hA006), 1'b0, 1'b1, 2'd2);
    step; valid_de1 = 1'b0;
    chk("fx_v0", 32'(valid_uc1), 1);
    chk("fx_idx0", 32'(flow_idx_uc1), 0);
    #1 chk("fx_rdy0", 32'(ucode_ready_uc0), 0);
    step;
    chk("fx_idx1", 32'(flow_idx_uc1), 1);
    chk("fx_rdy1", 32'(ucode_ready_uc0), 0);
    step;
    chk("fx_idx2", 32'(flow_idx_uc1), 2);
    chk("fx_eom2", 32'(eom_uc1), 1);
    chk("fx_rdy2", 32'(ucode_ready_uc0), 1);
    step;
    chk("fx_drain", 32'(valid_uc1), 0);

    // Stall for 4 cycles while idx 1 is presented
    p = mk(32'h300, 8'h01, 8'h86, 5'd3, 5'd1, 5'd2, 16'h0);
    issue("st_ready", p);
    push(mk(32'h300, 8'h01, 8'h44, 5'd4, 5'd0, 5'd0, 16'hA004), 1'b1, 1'b0, 2'd0);
    push(mk(32'h300, 8'h01, 8'h45, 5'd5, 5'd0, 5'd0, 16'hA005), 1'b0, 1'b0, 2'd1);
    push(mk(32'h300, 8'h01, 8'h46, 5'd6, 5'd0, 5'd0, 16'hA006), 1'b0, 1'b1, 2'd2);
    step; valid_de1 = 1'b0;
    step;
    rename_ready_rn0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step;
      chk("st_valid", 32'(valid_uc1), 1);
      chk("st_idx_hold", 32'(flow_idx_uc1), 1);
      chku("st_uinstr_hold", uinstr_uc1, mk(32'h300, 8'h01, 8'h45, 5'd5, 5'd0, 5'd0, 16'hA005));
    end
    rename_ready_rn0 = 1'b1;
    step;
    chk("st_idx2_after", 32'(flow_idx_uc1), 2);
    step;
    chk("st_drain", 32'(valid_uc1), 0);

    // Nuke while idx 1 is presented; idx 1 is still emitted, idx 2 never is
    p = mk(32'h400, 8'h02, 8'h86, 5'd1, 5'd4, 5'd5, 16'h0055);
    issue("nk_ready", p);
    push(mk(32'h400, 8'h02, 8'h44, 5'd4, 5'd0, 5'd0, 16'hA004), 1'b1, 1'b0, 2'd0);
    push(mk(32'h400, 8'h02, 8'h45, 5'd5, 5'd0, 5'd0, 16'hA005), 1'b0, 1'b0, 2'd1);
    push(mk(32'h400, 8'h02, 8'h46, 5'd6, 5'd0, 5'd0, 16'hA006), 1'b0, 1'b1, 2'd2);
    step; valid_de1 = 1'b0;
    step;
    chk("nk_idx1", 32'(flow_idx_uc1), 1);
    nuke_rb1.valid = 1'b1;
    #1 chk("nk_ready_low", 32'(ucode_ready_uc0), 0);
    step;
    nuke_rb1.valid = 1'b0;
    chk("nk_valid_cleared", 32'(valid_uc1), 0);
    chk("nk_q_left", exp_q.size(), 1);
    exp_q.delete();
    p = mk(32'h500, 8'h09, 8'h21, 5'd2, 5'd6, 5'd7, 16'h0077);
    issue("nk_next_ready", p);
    push(p, 1'b1, 1'b1, 2'd0);
    step; valid_de1 = 1'b0;
    chk("nk_next_valid", 32'(valid_uc1), 1);
    chk("nk_next_sop_eom_idx", 32'({sop_uc1, eom_uc1, flow_idx_uc1}), 32'h0C);
    step;
    chk("nk_drain", 32'(valid_uc1), 0);

    // Reset for one cycle at idx 1 of a len-4 flow
    p = mk(32'h600, 8'h03, 8'h8B, 5'd4, 5'd8, 5'd9, 16'hBEEF);
    issue("rs_ready", p);
    push(mk(32'h600, 8'h03, 8'h48, 5'd8, 5'd0, 5'd0, 16'hA008), 1'b1, 1'b0, 2'd0);
    push(mk(32'h600, 8'h03, 8'h49, 5'd9, 5'd0, 5'd0, 16'hA009), 1'b0, 1'b0, 2'd1);
    push(mk(32'h600, 8'h03, 8'h4A, 5'd10, 5'd0, 5'd0, 16'hA00A), 1'b0, 1'b0, 2'd2);
    push(mk(32'h600, 8'h03, 8'h4B, 5'd11, 5'd0, 5'd0, 16'hA00B), 1'b0, 1'b1, 2'd3);
    step; valid_de1 = 1'b0;
    step;
    chk("rs_idx1", 32'(flow_idx_uc1), 1);
    reset = 1'b1; rename_ready_rn0 = 1'b0;
    #1 chk("rs_ready_low", 32'(ucode_ready_uc0), 0);
    step;
    reset = 1'b0; rename_ready_rn0 = 1'b1;
    chk("rs_valid", 32'(valid_uc1), 0);
    chk("rs_sop_eom_idx", 32'({sop_uc1, eom_uc1, flow_idx_uc1}), 0);
    chku("rs_uinstr", uinstr_uc1, '0);
    #1 chk("rs_ready_after", 32'(ucode_ready_uc0), 1);
    chk("rs_q_left", exp_q.size(), 3);
    exp_q.delete();
    step;
    chk("rs_no_stale", 32'(valid_uc1), 0);

    // MAX_FLOW parent then a single-uop parent with no bubble
    p = mk(32'h700, 8'h04, 8'h9F, 5'd0, 5'd1, 5'd1, 16'h0);
    issue("bd_ready", p);
    push(mk(32'h700, 8'h04, 8'h5C, 5'd28, 5'd0, 5'd0, 16'hA01C), 1'b1, 1'b0, 2'd0);
    push(mk(32'h700, 8'h04, 8'h5D, 5'd29, 5'd0, 5'd0, 16'hA01D), 1'b0, 1'b0, 2'd1);
    push(mk(32'h700, 8'h04, 8'h5E, 5'd30, 5'd0, 5'd0, 16'hA01E), 1'b0, 1'b0, 2'd2);
    push(mk(32'h700, 8'h04, 8'h5F, 5'd31, 5'd0, 5'd0, 16'hA01F), 1'b0, 1'b1, 2'd3);
    step; valid_de1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bd_valid", 32'(valid_uc1), 1);
      chk("bd_idx", 32'(flow_idx_uc1), 32'(k));
      step;
    end
    chk("bd_idx3", 32'(flow_idx_uc1), 3);
    chk("bd_eom3", 32'(eom_uc1), 1);
    p = mk(32'h704, 8'h04, 8'h33, 5'd3, 5'd2, 5'd2, 16'h0004);
    issue("bd_next_ready", p);
    push(p, 1'b1, 1'b1, 2'd0);
    step; valid_de1 = 1'b0;
    chk("bd_next_valid", 32'(valid_uc1), 1);
    chk("bd_next_sop_eom_idx", 32'({sop_uc1, eom_uc1, flow_idx_uc1}), 32'h0C);
    step;
    chk("bd_drain", 32'(valid_uc1), 0);

    step;
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
